// File: rtl/sqwave_pkg.sv
// Shared definitions for the square-wave generator.
//   HALF_W  : width of half-period values (clk_6M cycles)
//   CNT_W   : width of the completed-period counter
//   BURST_W : width of the burst length
//   CLK_HZ  : nominal clk_6M frequency
//   state_e : generator FSM states; StDone exists only when SQWAVE_BURST_EN is defined
//   sat_half: maps a requested half-period of 0 to 1

package sqwave_pkg;

    localparam int unsigned HALF_W  = 24;
    localparam int unsigned CNT_W   = 28;
    localparam int unsigned BURST_W = 16;
    localparam int unsigned CLK_HZ  = 6_000_000;

`ifdef SQWAVE_BURST_EN
    typedef enum logic [1:0] {StIdle, StRun, StStop, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;
`endif

    // A zero half-period would never reach terminal count; clamp to the 3 MHz maximum.
    function automatic logic [HALF_W-1:0] sat_half(input logic [HALF_W-1:0] val);
        return (val == '0) ? HALF_W'(1) : val;
    endfunction

endpackage

// File: rtl/sqwave_timer.sv
// Phase timer for sqwave_gen: counts 0..i_half-1 while running and flags the last cycle.
// Ports:
//   clk_6M     : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   i_run      : count enable; counter is held at 0 while low
//   i_half     : current half-period length in cycles (never 0)
//   o_terminal : high in the last cycle of a phase (only while i_run)

module sqwave_timer
    import sqwave_pkg::*;
(
    input  logic              clk_6M,
    input  logic              reset_n,
    input  logic              i_run,
    input  logic [HALF_W-1:0] i_half,
    output logic              o_terminal
);

    logic [HALF_W-1:0] r_phase_cnt;
    logic              w_terminal;

    assign w_terminal = i_run && (r_phase_cnt == i_half - HALF_W'(1));
    assign o_terminal = w_terminal;

    always_ff @(posedge clk_6M or negedge reset_n) begin
        if (!reset_n) begin
            r_phase_cnt <= '0;
        end else if (!i_run || w_terminal) begin
            r_phase_cnt <= '0;
        end else begin
            r_phase_cnt <= r_phase_cnt + HALF_W'(1);
        end
    end

endmodule

// File: rtl/sqwave_gen.sv
// Programmable square-wave generator with a one-deep shadow register for the half-period.
// Optional burst mode is enabled by defining the macro SQWAVE_BURST_EN.
// Ports:
//   clk_6M      : 6 MHz system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   enable      : 1 runs the generator, 0 stops it after the current high phase
//   half_period : requested half-period in clk_6M cycles (0 treated as 1)
//   cfg_valid   : half_period is valid
//   cfg_ready   : shadow register empty, a transfer is accepted
//   square      : registered square wave
//   square_pose : one-cycle pulse coincident with square rising
//   cycle_cnt   : completed periods (falling edges) since the last start
//   burst_len   : (SQWAVE_BURST_EN) periods per burst, 0 = continuous, sampled at start
//   burst_done  : (SQWAVE_BURST_EN) one-cycle pulse when a burst completes

module sqwave_gen
    import sqwave_pkg::*;
#(
    parameter logic [HALF_W-1:0] DEFAULT_HALF = 24'd3000
) (
    input  logic              clk_6M,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [HALF_W-1:0] half_period,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              square,
    output logic              square_pose,
    output logic [CNT_W-1:0]  cycle_cnt
`ifdef SQWAVE_BURST_EN
    ,
    input  logic [BURST_W-1:0] burst_len,
    output logic               burst_done
`endif
);

    state_e             r_state;
    state_e             w_state_d;
    logic               r_square;
    logic               w_square_d;
    logic               r_pose;
    logic               w_pose_d;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   w_cycle_d;
    logic [CNT_W-1:0]   w_cycle_inc;
    logic [HALF_W-1:0]  r_cur_half;
    logic [HALF_W-1:0]  r_shadow;
    logic               r_shadow_full;
    logic               w_run;
    logic               w_toggle;
    logic               w_fall;
    logic               w_apply;
    logic               w_start;

`ifdef SQWAVE_BURST_EN
    logic [BURST_W-1:0] r_burst_len;
    logic               r_burst_done;
    logic               w_done_d;
    logic               w_burst_hit;

    // The falling edge being taken now is the last one of a finite burst.
    assign w_burst_hit = (r_burst_len != '0)
                      && ({{(CNT_W-BURST_W){1'b0}}, r_burst_len} == w_cycle_inc);
`endif

    assign w_run       = (r_state == StRun) || (r_state == StStop);
    assign w_fall      = w_toggle && r_square;
    assign w_cycle_inc = r_cycle_cnt + CNT_W'(1);

    sqwave_timer u_timer (
        .clk_6M     (clk_6M),
        .reset_n    (reset_n),
        .i_run      (w_run),
        .i_half     (r_cur_half),
        .o_terminal (w_toggle)
    );

    always_comb begin
        w_state_d  = r_state;
        w_square_d = r_square;
        w_pose_d   = 1'b0;
        w_cycle_d  = r_cycle_cnt;
        w_start    = 1'b0;
`ifdef SQWAVE_BURST_EN
        w_done_d   = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (enable) begin
                    w_state_d  = StRun;
                    w_square_d = 1'b1;
                    w_pose_d   = 1'b1;
                    w_cycle_d  = '0;
                    w_start    = 1'b1;
                end
            end
            StRun: begin
`ifdef SQWAVE_BURST_EN
                if (w_fall && w_burst_hit) begin
                    w_state_d  = StDone;
                    w_square_d = 1'b0;
                    w_cycle_d  = w_cycle_inc;
                    w_done_d   = 1'b1;
                end else
`endif
                if (!enable) begin
                    // High phase ending right now needs no STOP detour.
                    if (w_fall) begin
                        w_state_d  = StIdle;
                        w_square_d = 1'b0;
                        w_cycle_d  = w_cycle_inc;
                    end else if (r_square) begin
                        w_state_d = StStop;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else if (w_toggle) begin
                    w_square_d = ~r_square;
                    w_pose_d   = ~r_square;
                    if (r_square) begin
                        w_cycle_d = w_cycle_inc;
                    end
                end
            end
            StStop: begin
                // Only entered with square high; enable is ignored until the phase ends.
                if (w_toggle) begin
                    w_state_d  = StIdle;
                    w_square_d = 1'b0;
                    w_cycle_d  = w_cycle_inc;
                end
            end
`ifdef SQWAVE_BURST_EN
            StDone: begin
                if (!enable) begin
                    w_state_d = StIdle;
                end
            end
`endif
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_6M or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_square    <= 1'b0;
            r_pose      <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_square    <= w_square_d;
            r_pose      <= w_pose_d;
            r_cycle_cnt <= w_cycle_d;
        end
    end

    // Shadow is applied on a phase boundary while running, otherwise immediately.
    // A transfer needs an empty shadow, so it can never coincide with its own apply.
    assign w_apply = r_shadow_full && (w_run ? w_toggle : 1'b1);

    always_ff @(posedge clk_6M or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_half    <= sat_half(DEFAULT_HALF);
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
        end else begin
            if (w_apply) begin
                r_cur_half    <= r_shadow;
                r_shadow_full <= 1'b0;
            end
            if (cfg_valid && !r_shadow_full) begin
                r_shadow      <= sat_half(half_period);
                r_shadow_full <= 1'b1;
            end
        end
    end

`ifdef SQWAVE_BURST_EN
    always_ff @(posedge clk_6M or negedge reset_n) begin
        if (!reset_n) begin
            r_burst_len  <= '0;
            r_burst_done <= 1'b0;
        end else begin
            if (w_start) begin
                r_burst_len <= burst_len;
            end
            r_burst_done <= w_done_d;
        end
    end

    assign burst_done = r_burst_done;
`endif

    assign cfg_ready   = ~r_shadow_full;
    assign square      = r_square;
    assign square_pose = r_pose;
    assign cycle_cnt   = r_cycle_cnt;

endmodule

// File: tb/tb_sqwave_gen.sv
// Self-checking bench for sqwave_gen: a vector table from reset, hand-written multi-cycle
// sequences, and randomized stimulus against a countdown reference model.

module tb_sqwave_gen;

    localparam int HALF_1K = sqwave_pkg::CLK_HZ / (2 * 1000);

    logic        clk_6M = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [23:0] half_period;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        square;
    logic        square_pose;
    logic [27:0] cycle_cnt;
`ifdef SQWAVE_BURST_EN
    logic [15:0] burst_len;
    logic        burst_done;
`endif

    int checks   = 0;
    int failures = 0;

    sqwave_gen dut (
        .clk_6M      (clk_6M),
        .reset_n     (reset_n),
        .enable      (enable),
        .half_period (half_period),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .square      (square),
        .square_pose (square_pose),
        .cycle_cnt   (cycle_cnt)
`ifdef SQWAVE_BURST_EN
        ,
        .burst_len   (burst_len),
        .burst_done  (burst_done)
`endif
    );

    always #83 clk_6M = ~clk_6M;

    initial begin
        #50_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic do_reset();
        enable      = 1'b0;
        cfg_valid   = 1'b0;
        half_period = '0;
`ifdef SQWAVE_BURST_EN
        burst_len   = '0;
`endif
        reset_n     = 1'b0;
        repeat (2) step();
        #20 reset_n = 1'b1;
    endtask

    // Counts samples (current one included) while square stays at lvl.
    task automatic measure(input logic lvl, input int bound, output int n, output logic last_rdy);
        n        = 0;
        last_rdy = cfg_ready;
        while (square == lvl && n < bound) begin
            n++;
            last_rdy = cfg_ready;
            step();
        end
    endtask

    // Reference model: phase tracked as cycles remaining, one update per clock edge.
    localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_DONE = 3;
    int          m_mode;
    int          m_left;
    logic        m_level, m_pose, m_pend, m_done;
    logic [27:0] m_cnt;
    logic [23:0] m_half, m_pval;
    logic [15:0] m_blen;

    task automatic model_reset();
        m_mode = M_IDLE; m_left = 0; m_level = 0; m_pose = 0; m_pend = 0; m_done = 0;
        m_cnt = 0; m_half = 24'd3000; m_pval = 0; m_blen = 0;
    endtask

    task automatic model_step(input logic en, input logic valid, input logic [23:0] hp,
                              input logic [15:0] blen);
        logic        at_end, apply, xfer;
        logic [23:0] half_next;
        at_end    = (m_mode == M_RUN || m_mode == M_STOP) && m_left == 1;
        apply     = m_pend && (m_mode == M_IDLE || m_mode == M_DONE || at_end);
        xfer      = valid && !m_pend;
        half_next = apply ? m_pval : m_half;
        m_pose    = 0;
        m_done    = 0;
        case (m_mode)
            M_IDLE: if (en) begin
                m_mode = M_RUN; m_level = 1; m_pose = 1; m_cnt = 0;
                m_left = int'(half_next); m_blen = blen;
            end
            M_RUN: begin
                if (at_end && m_level && m_blen != 0 && (m_cnt + 1) == m_blen) begin
                    m_mode = M_DONE; m_level = 0; m_cnt++; m_done = 1;
                end else if (!en) begin
                    if (at_end && m_level) begin
                        m_level = 0; m_cnt++; m_mode = M_IDLE;
                    end else if (m_level) begin
                        m_mode = M_STOP; m_left--;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end else if (at_end) begin
                    m_level = !m_level;
                    if (m_level) m_pose = 1;
                    else m_cnt++;
                    m_left = int'(half_next);
                end else begin
                    m_left--;
                end
            end
            M_STOP: begin
                if (at_end) begin
                    m_level = 0; m_cnt++; m_mode = M_IDLE;
                end else begin
                    m_left--;
                end
            end
            default: if (!en) m_mode = M_IDLE;
        endcase
        if (apply) begin
            m_half = m_pval;
            m_pend = 0;
        end
        if (xfer) begin
            m_pend = 1;
            m_pval = (hp == 0) ? 24'd1 : hp;
        end
    endtask

    typedef struct {
        logic        en;
        logic        valid;
        logic [23:0] hp;
        logic        sq;
        logic        pose;
        logic [27:0] cnt;
        logic        rdy;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic valid, input int hp, input logic sq,
                                input logic pose, input int cnt, input logic rdy);
        vec_t v;
        v.en = en; v.valid = valid; v.hp = 24'(hp);
        v.sq = sq; v.pose = pose; v.cnt = 28'(cnt); v.rdy = rdy;
        return v;
    endfunction

    initial begin
        vec_t        vecs[21];
        int          n;
        int          f0;
        logic        lr;
        logic        en_r;
        logic [15:0] blen_v;

        // en, valid, hp -> square, pose, cycle_cnt, cfg_ready (after the edge)
        vecs[0]  = mk(0, 1, 0, 0, 0, 0, 0);  // load 0 into shadow in IDLE
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1);  // applied next cycle, half = 1
        vecs[2]  = mk(1, 0, 0, 1, 1, 0, 1);  // start
        vecs[3]  = mk(1, 0, 0, 0, 0, 1, 1);
        vecs[4]  = mk(1, 0, 0, 1, 1, 1, 1);
        vecs[5]  = mk(1, 0, 0, 0, 0, 2, 1);
        vecs[6]  = mk(1, 1, 2, 1, 1, 2, 0);  // loaded on a toggle: not applied yet
        vecs[7]  = mk(1, 0, 0, 0, 0, 3, 1);  // applied on following toggle
        vecs[8]  = mk(1, 0, 0, 0, 0, 3, 1);
        vecs[9]  = mk(1, 0, 0, 1, 1, 3, 1);
        vecs[10] = mk(1, 0, 0, 1, 0, 3, 1);
        vecs[11] = mk(1, 0, 0, 0, 0, 4, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 4, 1);  // stop in low phase
        vecs[13] = mk(0, 0, 0, 0, 0, 4, 1);  // count held in IDLE
        vecs[14] = mk(1, 0, 0, 1, 1, 0, 1);  // restart clears count
        vecs[15] = mk(0, 0, 0, 1, 0, 0, 1);  // stop in high phase -> STOP
        vecs[16] = mk(1, 0, 0, 0, 0, 1, 1);  // phase completes, enable ignored
        vecs[17] = mk(1, 0, 0, 1, 1, 0, 1);  // restart from IDLE
        vecs[18] = mk(0, 0, 0, 1, 0, 0, 1);
        vecs[19] = mk(0, 0, 0, 0, 0, 1, 1);
        vecs[20] = mk(0, 0, 0, 0, 0, 1, 1);

        // Reset state
        enable = 0; cfg_valid = 0; half_period = 0; reset_n = 0;
`ifdef SQWAVE_BURST_EN
        burst_len = 0;
`endif
        repeat (2) step();
        check("reset_square", 64'(square), 64'(0));
        check("reset_pose", 64'(square_pose), 64'(0));
        check("reset_cycle_cnt", 64'(cycle_cnt), 64'(0));
        check("reset_cfg_ready", 64'(cfg_ready), 64'(1));
`ifdef SQWAVE_BURST_EN
        check("reset_burst_done", 64'(burst_done), 64'(0));
`endif
        #20 reset_n = 1'b1;

        // Vector table
        for (int i = 0; i < 21; i++) begin
            enable = vecs[i].en; cfg_valid = vecs[i].valid; half_period = vecs[i].hp;
            step();
            check($sformatf("vec_%0d", i), 64'({square, square_pose, cfg_ready, cycle_cnt}),
                  64'({vecs[i].sq, vecs[i].pose, vecs[i].rdy, vecs[i].cnt}));
        end

        // Default 1 kHz after reset
        do_reset();
        enable = 1;
        step();
        check("start_square", 64'(square), 64'(1));
        check("start_pose", 64'(square_pose), 64'(1));
        check("start_cycle_cnt", 64'(cycle_cnt), 64'(0));
        for (int k = 1; k <= 3; k++) begin
            measure(1'b1, 4000, n, lr);
            check($sformatf("def_high_%0d", k), 64'(n), 64'(HALF_1K));
            check($sformatf("def_cnt_%0d", k), 64'(cycle_cnt), 64'(k));
            measure(1'b0, 4000, n, lr);
            check($sformatf("def_low_%0d", k), 64'(n), 64'(HALF_1K));
            check($sformatf("def_pose_%0d", k), 64'(square_pose), 64'(1));
        end

        // Transfer 3 in the middle of a high phase
        repeat (999) step();
        cfg_valid = 1; half_period = 24'd3;
        step();
        cfg_valid = 0;
        check("mid_xfer_ready", 64'(cfg_ready), 64'(0));
        measure(1'b1, 4000, n, lr);
        check("mid_rest_high", 64'(n), 64'(2000));
        check("mid_ready_last_high", 64'(lr), 64'(0));
        check("mid_ready_after", 64'(cfg_ready), 64'(1));
        measure(1'b0, 100, n, lr);
        check("h3_low_a", 64'(n), 64'(3));
        measure(1'b1, 100, n, lr);
        check("h3_high", 64'(n), 64'(3));
        measure(1'b0, 100, n, lr);
        check("h3_low_b", 64'(n), 64'(3));
        check("h3_cnt", 64'(cycle_cnt), 64'(5));

        // half_period = 0 -> 1 high, 1 low
        cfg_valid = 1; half_period = 24'd0;
        step();
        cfg_valid = 0;
        check("h0_ready", 64'(cfg_ready), 64'(0));
        measure(1'b1, 100, n, lr);
        check("h0_rest_high", 64'(n), 64'(2));
        measure(1'b0, 100, n, lr);
        check("h0_low", 64'(n), 64'(1));
        measure(1'b1, 100, n, lr);
        check("h0_high", 64'(n), 64'(1));
        measure(1'b0, 100, n, lr);
        check("h0_low_b", 64'(n), 64'(1));

        // Back-to-back transfers: second waits for cfg_ready
        cfg_valid = 1; half_period = 24'd4;
        step();
        check("b2b_ready_first", 64'(cfg_ready), 64'(0));
        half_period = 24'd7;
        step();
        check("b2b_ready_applied", 64'(cfg_ready), 64'(1));
        step();
        cfg_valid = 0;
        check("b2b_ready_second", 64'(cfg_ready), 64'(0));
        measure(1'b1, 100, n, lr);
        check("b2b_rest_first", 64'(n), 64'(3));
        measure(1'b0, 100, n, lr);
        check("b2b_second_len", 64'(n), 64'(7));

        // Asynchronous reset in a high phase
        check("pre_reset_square", 64'(square), 64'(1));
        #20 reset_n = 1'b0;
        enable = 0;
        #1;
        check("async_square", 64'(square), 64'(0));
        check("async_ready", 64'(cfg_ready), 64'(1));
        check("async_cnt", 64'(cycle_cnt), 64'(0));
        step();
        #20 reset_n = 1'b1;

        // enable=0 two cycles into a high phase; enable=1 during STOP ignored
        enable = 1;
        step();
        step();
        enable = 0;
        step();
        check("stop_holds_high", 64'(square), 64'(1));
        repeat (97) step();
        enable = 1;
        measure(1'b1, 4000, n, lr);
        check("stop_high_total", 64'(99 + n), 64'(HALF_1K));
        check("stop_cnt", 64'(cycle_cnt), 64'(1));
        step();
        check("restart_square", 64'(square), 64'(1));
        check("restart_pose", 64'(square_pose), 64'(1));
        check("restart_cnt", 64'(cycle_cnt), 64'(0));
        measure(1'b1, 4000, n, lr);
        check("restart_high", 64'(n), 64'(HALF_1K));
        enable = 0;
        step();
        enable = 1;
        step();
        check("low_stop_restart_sq", 64'(square), 64'(1));
        check("low_stop_restart_cnt", 64'(cycle_cnt), 64'(0));

`ifdef SQWAVE_BURST_EN
        // Burst of 5 periods at half 10
        begin
            int poses;
            int dones;
            do_reset();
            cfg_valid = 1; half_period = 24'd10;
            step();
            cfg_valid = 0;
            step();
            burst_len = 16'd5;
            enable = 1;
            poses = 0;
            dones = 0;
            for (int i = 0; i < 300; i++) begin
                step();
                poses += int'(square_pose);
                dones += int'(burst_done);
            end
            check("burst_poses", 64'(poses), 64'(5));
            check("burst_dones", 64'(dones), 64'(1));
            check("burst_cnt", 64'(cycle_cnt), 64'(5));
            check("burst_square", 64'(square), 64'(0));
            enable = 0;
            step();
            enable = 1;
            step();
            check("burst_restart_sq", 64'(square), 64'(1));
            check("burst_restart_cnt", 64'(cycle_cnt), 64'(0));
        end
`endif

        // Randomized stimulus against the model
        do_reset();
        model_reset();
        en_r   = 0;
        blen_v = 0;
        f0     = failures;
        for (int i = 0; i < 4000 && (failures - f0) < 5; i++) begin
            if (i == 30) en_r = 1;
            else if (i > 30 && $urandom_range(0, 59) == 0) en_r = !en_r;
            enable      = en_r;
            cfg_valid   = ($urandom_range(0, 7) == 0);
            half_period = 24'($urandom_range(0, 6));
`ifdef SQWAVE_BURST_EN
            blen_v      = 16'($urandom_range(0, 3));
            burst_len   = blen_v;
`endif
            model_step(enable, cfg_valid, half_period, blen_v);
            step();
            check($sformatf("rand_%0d", i),
                  64'({square, square_pose, cfg_ready, cycle_cnt}),
                  64'({m_level, m_pose, !m_pend, m_cnt}));
`ifdef SQWAVE_BURST_EN
            check($sformatf("rand_done_%0d", i), 64'(burst_done), 64'(m_done));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
